// File: rtl/wrr_handshake_arbiter_if.sv
// Handshake bundle between requesters/downstream (master) and the weighted
// round-robin arbiter (slave).
interface wrr_handshake_arbiter_if #(
  parameter int NUM_REQS     = 4,
  parameter int WEIGHT_BITS  = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
  logic [NUM_REQS-1:0]             requests;
  logic [NUM_REQS*WEIGHT_BITS-1:0] weights;
  logic                            grant_ready;
  logic                            grant_valid;
  logic [LOG_NUM_REQS-1:0]         grant_index;
  logic [NUM_REQS-1:0]             grant_onehot;
  logic                            locked;

  modport master (
    output requests, weights, grant_ready,
    input  grant_valid, grant_index, grant_onehot, locked
  );

  modport slave (
    input  requests, weights, grant_ready,
    output grant_valid, grant_index, grant_onehot, locked
  );
endinterface

// File: rtl/wrr_handshake_arbiter.sv
// Weighted round-robin arbiter: holds a grant for up to a per-requester quantum of
// accepted transfers, then rotates. Optional stall counter under WRR_ARBITER_PERF_EN.
module wrr_handshake_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int WEIGHT_BITS  = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  wrr_handshake_arbiter_if.slave  bus
`ifdef WRR_ARBITER_PERF_EN
  , output logic [31:0]           perf_stalls
`endif
);

  logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
  logic                    locked_q, locked_d;
  logic [WEIGHT_BITS-1:0]  rem_q, rem_d;

  logic [LOG_NUM_REQS-1:0] winner_s, cand_s;
  logic                    found_s;
  logic                    eff_lock_s;
  logic                    any_req_s;
  logic                    fire_s;
  logic [WEIGHT_BITS-1:0]  weight_s, quantum_s, rem_next_s;

  // Winner selection: keep the owner while its lock holds, else search from ptr+1 with wrap.
  always_comb begin
    eff_lock_s = locked_q & bus.requests[ptr_q];
    winner_s   = {LOG_NUM_REQS{1'b0}};
    cand_s     = {LOG_NUM_REQS{1'b0}};
    found_s    = 1'b0;
    if (eff_lock_s) begin
      winner_s = ptr_q;
      found_s  = 1'b1;
    end else begin
      for (int off = 1; off <= NUM_REQS; off++) begin
        cand_s = LOG_NUM_REQS'((int'(ptr_q) + off) % NUM_REQS);
        if (!found_s && bus.requests[cand_s]) begin
          winner_s = cand_s;
          found_s  = 1'b1;
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  // Quantum bookkeeping and the externally visible grant.
  always_comb begin
    any_req_s  = |bus.requests;
    fire_s     = any_req_s & bus.grant_ready;
    weight_s   = bus.weights[int'(winner_s)*WEIGHT_BITS +: WEIGHT_BITS];
    // Weights are only consulted when a fresh quantum starts; zero behaves as one.
    if (eff_lock_s) begin
      quantum_s = rem_q;
    end else if (weight_s == {WEIGHT_BITS{1'b0}}) begin
      quantum_s = WEIGHT_BITS'(1);
    end else begin
      quantum_s = weight_s;
    end
    rem_next_s = quantum_s - WEIGHT_BITS'(1);

    bus.grant_valid = any_req_s;
    bus.locked      = locked_q;
    if (any_req_s) begin
      bus.grant_index  = winner_s;
      bus.grant_onehot = NUM_REQS'(1) << winner_s;
    end else begin
      bus.grant_index  = {LOG_NUM_REQS{1'b0}};
      bus.grant_onehot = {NUM_REQS{1'b0}};
    end
  end

  // Next state: advance on fire, abandon a lock whose owner stopped requesting.
  always_comb begin
    ptr_d    = ptr_q;
    locked_d = locked_q;
    rem_d    = rem_q;
    if (fire_s) begin
      ptr_d = winner_s;
      if (rem_next_s == {WEIGHT_BITS{1'b0}}) begin
        locked_d = 1'b0;
      end else begin
        locked_d = 1'b1;
        rem_d    = rem_next_s;
      end
    end else if (locked_q && !eff_lock_s) begin
      locked_d = 1'b0;
    end else begin
      locked_d = locked_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= LOG_NUM_REQS'(NUM_REQS - 1);
      locked_q <= 1'b0;
      rem_q    <= {WEIGHT_BITS{1'b0}};
    end else begin
      ptr_q    <= ptr_d;
      locked_q <= locked_d;
      rem_q    <= rem_d;
    end
  end

`ifdef WRR_ARBITER_PERF_EN
  logic [31:0] stalls_q;

  // Saturating count of cycles where a grant is offered but not accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q <= 32'd0;
    end else if (any_req_s && !bus.grant_ready && (stalls_q != 32'hFFFF_FFFF)) begin
      stalls_q <= stalls_q + 32'd1;
    end else begin
      stalls_q <= stalls_q;
    end
  end

  assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_wrr_handshake_arbiter.sv
// Directed, table-driven bench for wrr_handshake_arbiter (NUM_REQS=4, WEIGHT_BITS=4).
module tb_wrr_handshake_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wrr_handshake_arbiter_if #(.NUM_REQS(4), .WEIGHT_BITS(4)) bus ();

`ifdef WRR_ARBITER_PERF_EN
  logic [31:0] perf_stalls;
  wrr_handshake_arbiter #(.NUM_REQS(4), .WEIGHT_BITS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .perf_stalls(perf_stalls)
  );
`else
  wrr_handshake_arbiter #(.NUM_REQS(4), .WEIGHT_BITS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] w;
    logic        rdy;
    logic        v;
    logic [1:0]  idx;
    logic [3:0]  oh;
    logic        lk;   // locked after the clock edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic rst, input logic [3:0] req,
                     input logic [15:0] w, input logic rdy, input logic [1:0] idx,
                     input logic lk);
    vec_t e;
    logic [3:0] one;
    one    = 4'b0001;
    e.tag  = tag;
    e.rst  = rst;
    e.req  = req;
    e.w    = w;
    e.rdy  = rdy;
    e.v    = |req;
    e.idx  = (req != 4'b0000) ? idx : 2'd0;
    e.oh   = (req != 4'b0000) ? (one << idx) : 4'b0000;
    e.lk   = lk;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector shortly after a rising edge, check the grant, then check locked after the edge.
  task automatic apply(input vec_t v);
    reset           = v.rst;
    bus.requests    = v.req;
    bus.weights     = v.w;
    bus.grant_ready = v.rdy;
    #2;
    check({v.tag, ".valid"},  32'(bus.grant_valid),  32'(v.v));
    check({v.tag, ".index"},  32'(bus.grant_index),  32'(v.idx));
    check({v.tag, ".onehot"}, 32'(bus.grant_onehot), 32'(v.oh));
    @(posedge clk);
    #1;
    check({v.tag, ".locked"}, 32'(bus.locked), 32'(v.lk));
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic [15:0] w,
                       input logic rdy);
    vec_t e;
    e.tag = "seq"; e.rst = rst; e.req = req; e.w = w; e.rdy = rdy;
    e.v = 1'b0; e.idx = 2'd0; e.oh = 4'b0000; e.lk = 1'b0;
    reset = e.rst; bus.requests = e.req; bus.weights = e.w; bus.grant_ready = e.rdy;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.requests    = 4'b0000;
    bus.weights     = 16'h0000;
    bus.grant_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: plain round robin
    add("rst1", 1'b1, 4'b0000, 16'h1111, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) add("t1", 1'b0, 4'b1111, 16'h1111, 1'b1, 2'(i % 4), 1'b0);
    // T2: requester 0 weight 3
    add("rst2", 1'b1, 4'b0000, 16'h1113, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      add("t2", 1'b0, 4'b0011, 16'h1113, 1'b1, 2'd0, 1'b1);
      add("t2", 1'b0, 4'b0011, 16'h1113, 1'b1, 2'd0, 1'b1);
      add("t2", 1'b0, 4'b0011, 16'h1113, 1'b1, 2'd0, 1'b0);
      add("t2", 1'b0, 4'b0011, 16'h1113, 1'b1, 2'd1, 1'b0);
    end
    // T4: lock drop, with and without a simultaneous fire
    add("rst4", 1'b1, 4'b0000, 16'h2511, 1'b1, 2'd0, 1'b0);
    add("t4a", 1'b0, 4'b0100, 16'h2511, 1'b1, 2'd2, 1'b1);
    add("t4a", 1'b0, 4'b1011, 16'h2511, 1'b0, 2'd3, 1'b0);
    add("t4a", 1'b0, 4'b1011, 16'h2511, 1'b1, 2'd3, 1'b1);
    add("rst4", 1'b1, 4'b0000, 16'h2511, 1'b1, 2'd0, 1'b0);
    add("t4b", 1'b0, 4'b0100, 16'h2511, 1'b1, 2'd2, 1'b1);
    add("t4b", 1'b0, 4'b1011, 16'h2511, 1'b1, 2'd3, 1'b1);
    add("t4b", 1'b0, 4'b1011, 16'h2511, 1'b1, 2'd3, 1'b0);
    add("t4b", 1'b0, 4'b1011, 16'h2511, 1'b1, 2'd0, 1'b0);
    // T5: wrap, weight 0 as 1, reset mid-quantum
    add("rst5", 1'b1, 4'b0000, 16'h0000, 1'b1, 2'd0, 1'b0);
    add("t5", 1'b0, 4'b0101, 16'h0000, 1'b1, 2'd0, 1'b0);
    add("t5", 1'b0, 4'b0101, 16'h0000, 1'b1, 2'd2, 1'b0);
    add("t5", 1'b0, 4'b0101, 16'h0000, 1'b1, 2'd0, 1'b0);
    add("t5r", 1'b1, 4'b0101, 16'h0000, 1'b0, 2'd2, 1'b0);
    add("t5", 1'b0, 4'b0101, 16'h0004, 1'b1, 2'd0, 1'b1);
    add("t5r", 1'b1, 4'b0101, 16'h0004, 1'b1, 2'd0, 1'b0);
    add("t5", 1'b0, 4'b0101, 16'h0000, 1'b1, 2'd0, 1'b0);

    foreach (vecs[i]) apply(vecs[i]);

    // T3: stall mid-quantum; weight change during the stall must be ignored
    drive(1'b1, 4'b0000, 16'h1114, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b0011, 16'h1114, 1'b1);
      #2; check("t3.fire_idx", 32'(bus.grant_index), 32'd0);
      @(posedge clk); #1; check("t3.fire_lk", 32'(bus.locked), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0011, 16'h1FFF, 1'b0);
      #2; check("t3.stall_idx", 32'(bus.grant_index), 32'd0);
      check("t3.stall_oh", 32'(bus.grant_onehot), 32'h1);
      @(posedge clk); #1; check("t3.stall_lk", 32'(bus.locked), 32'd1);
    end
    drive(1'b0, 4'b0011, 16'h1FFF, 1'b1);
    #2; check("t3.tail1_idx", 32'(bus.grant_index), 32'd0);
    @(posedge clk); #1; check("t3.tail1_lk", 32'(bus.locked), 32'd1);
    #2; check("t3.tail2_idx", 32'(bus.grant_index), 32'd0);
    @(posedge clk); #1; check("t3.tail2_lk", 32'(bus.locked), 32'd0);
    #2; check("t3.rotate_idx", 32'(bus.grant_index), 32'd1);
    @(posedge clk); #1;

`ifdef WRR_ARBITER_PERF_EN
    // T6: stall counter
    drive(1'b1, 4'b0000, 16'h1111, 1'b0);
    @(posedge clk); #1;
    check("t6.clear", perf_stalls, 32'd0);
    drive(1'b0, 4'b0010, 16'h1111, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    drive(1'b0, 4'b0010, 16'h1111, 1'b1);
    check("t6.count", perf_stalls, 32'd7);
    @(posedge clk); #1;
    check("t6.hold", perf_stalls, 32'd7);
    drive(1'b1, 4'b0010, 16'h1111, 1'b0);
    @(posedge clk); #1;
    check("t6.reset", perf_stalls, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
